// File: rtl/mult_controller.sv
`timescale 1ns/1ps
// Control FSM for the sequential approximate multiplier: sequences datapath clear,
// operand load, left-normalisation, product capture, result right-shift and done.
module mult_controller (
   input  logic clk,
   input  logic initial_load_ps,
   input  logic start,
   input  logic a_shifting,
   input  logic b_shifting,
   input  logic r_shifting,
   output logic rst,
   output logic ld,
   output logic ld_l_shift,
   output logic ld_r_shift,
   output logic l_count_enable,
   output logic r_count_enable,
   output logic done
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WAIT_REL = 3'd1;
   localparam logic [2:0] INIT     = 3'd2;
   localparam logic [2:0] LOAD     = 3'd3;
   localparam logic [2:0] L_SHIFT  = 3'd4;
   localparam logic [2:0] MULT     = 3'd5;
   localparam logic [2:0] R_SHIFT  = 3'd6;
   localparam logic [2:0] DONE     = 3'd7;

   logic [2:0] state;
   logic [2:0] next_state;
   logic       l_shifting;

   assign l_shifting = a_shifting | b_shifting;

   // NOTE: sequential state is written with non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge initial_load_ps) begin
      if (!initial_load_ps) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: each combinational block assigns a default to every target first, so no
   // path through the case statement can leave a value held and infer a latch.
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE:     next_state = start ? WAIT_REL : IDLE;
         // Wait for start to drop so a held request launches only one operation.
         WAIT_REL: next_state = start ? WAIT_REL : INIT;
         INIT:     next_state = LOAD;
         LOAD:     next_state = L_SHIFT;
         L_SHIFT:  next_state = l_shifting ? L_SHIFT : MULT;
         MULT:     next_state = R_SHIFT;
         R_SHIFT:  next_state = r_shifting ? R_SHIFT : DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // rst, ld and done decode from state alone; shift enables follow the datapath
   // status combinationally so the counters stop on the same edge as the shifters.
   always_comb begin
      rst            = 1'b0;
      ld             = 1'b0;
      ld_l_shift     = 1'b0;
      ld_r_shift     = 1'b0;
      l_count_enable = 1'b0;
      r_count_enable = 1'b0;
      done           = 1'b0;
      case (state)
         INIT:    rst  = 1'b1;
         LOAD:    ld   = 1'b1;
         L_SHIFT: begin
            ld_l_shift     = l_shifting;
            l_count_enable = l_shifting;
         end
         R_SHIFT: begin
            ld_r_shift     = r_shifting;
            r_count_enable = r_shifting;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mult_controller.sv
`timescale 1ns/1ps
// Self-checking bench for mult_controller: a small datapath emulator answers the
// shift handshakes and a scoreboard of per-operation expectations is checked at done.
module tb_mult_controller;

   logic clk;
   logic initial_load_ps;
   logic start;
   logic a_shifting, b_shifting, r_shifting;
   logic rst, ld, ld_l_shift, ld_r_shift, l_count_enable, r_count_enable, done;

   mult_controller dut (
      .clk            (clk),
      .initial_load_ps(initial_load_ps),
      .start          (start),
      .a_shifting     (a_shifting),
      .b_shifting     (b_shifting),
      .r_shifting     (r_shifting),
      .rst            (rst),
      .ld             (ld),
      .ld_l_shift     (ld_l_shift),
      .ld_r_shift     (ld_r_shift),
      .l_count_enable (l_count_enable),
      .r_count_enable (r_count_enable),
      .done           (done)
   );

   typedef struct {
      int l_cycles;
      int r_cycles;
      int latency;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] outs;
   assign outs = {rst, ld, ld_l_shift, ld_r_shift, l_count_enable, r_count_enable, done};

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Datapath emulator: shift counts load on ld and count down on each enabled cycle.
   bit direct;
   logic a_dir, b_dir, r_dir;
   int a_cfg, b_cfg, r_cfg;
   int a_cnt, b_cnt, r_cnt;

   always @(posedge clk or negedge initial_load_ps) begin
      if (!initial_load_ps) begin
         a_cnt <= 0;
         b_cnt <= 0;
         r_cnt <= 0;
      end else if (ld) begin
         a_cnt <= a_cfg;
         b_cnt <= b_cfg;
         r_cnt <= r_cfg;
      end else begin
         if (ld_l_shift && a_cnt != 0) a_cnt <= a_cnt - 1;
         if (ld_l_shift && b_cnt != 0) b_cnt <= b_cnt - 1;
         if (ld_r_shift && r_cnt != 0) r_cnt <= r_cnt - 1;
      end
   end

   assign a_shifting = direct ? a_dir : (a_cnt != 0);
   assign b_shifting = direct ? b_dir : (b_cnt != 0);
   assign r_shifting = direct ? r_dir : (r_cnt != 0);

   // Monitor: per-cycle invariants plus per-operation accounting checked against the scoreboard.
   bit   in_op;
   int   idx, lc, rc, ldc;
   exp_t e;

   always @(negedge clk) begin
      if (!initial_load_ps) begin
         in_op = 1'b0;
      end else begin
         check("mutex", int'($countones({rst, ld, ld_l_shift, ld_r_shift, done}) <= 1), 1);
         check("l_count_tracks_shift", int'(l_count_enable), int'(ld_l_shift));
         check("r_count_tracks_shift", int'(r_count_enable), int'(ld_r_shift));
         if (rst) begin
            check("single_rst", int'(in_op), 0);
            in_op = 1'b1;
            idx = 0; lc = 0; rc = 0; ldc = 0;
         end else if (in_op) begin
            idx++;
         end
         if (in_op) begin
            if (ld) begin
               ldc++;
               check("ld_slot", idx, 1);
            end
            lc += int'(ld_l_shift);
            rc += int'(ld_r_shift);
         end else begin
            check("idle_quiet", int'({ld, ld_l_shift, ld_r_shift, done}), 0);
         end
         if (done && in_op) begin
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("l_shift_cycles", lc, e.l_cycles);
               check("r_shift_cycles", rc, e.r_cycles);
               check("latency_from_rst", idx, e.latency);
               check("ld_count", ldc, 1);
            end else begin
               check("done_without_request", int'(done), 0);
            end
            in_op = 1'b0;
         end
      end
   end

   task automatic run_op(input int a_n, input int b_n, input int r_n, input int hold);
      int  m;
      bit  seen;
      exp_t x;
      m = (a_n > b_n) ? a_n : b_n;
      a_cfg = a_n; b_cfg = b_n; r_cfg = r_n;
      x.l_cycles = m;
      x.r_cycles = r_n;
      x.latency  = 5 + m + r_n;
      sb.push_back(x);
      @(posedge clk); #1 start = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_no_rst_ld", int'(rst | ld), 0);
      end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("rst_not_early", int'(rst), 0);
      @(negedge clk);
      check("rst_after_release", int'(rst), 1);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", int'(seen), 1);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
   endtask

   bit seen_r;

   initial begin
      direct = 1'b1;
      a_dir = 1'b0; b_dir = 1'b0; r_dir = 1'b0;
      a_cfg = 0; b_cfg = 0; r_cfg = 0;
      start = 1'b0;
      initial_load_ps = 1'b0;

      // Nominal run on absolute times; input edges placed 1 ns before the quoted times.
      begin
         exp_t n;
         n.l_cycles = 3; n.r_cycles = 3; n.latency = 11;
         sb.push_back(n);
      end
      #1  check("por_outputs", int'(outs), 0);
      #1  initial_load_ps = 1'b1;                         // t=2
      #17 start = 1'b1;                                   // t=19
      #10 start = 1'b0;                                   // t=29
      #1  check("nom_wait_rel_no_rst", int'(rst), 0);     // t=30
      #10 check("nom_rst_40", int'(rst), 1);              // t=40
      #10 check("nom_ld_50", int'(ld), 1);                // t=50
          check("nom_rst_low_50", int'(rst), 0);
      #7  check("nom_lshift_idle_57", int'(ld_l_shift), 0); // t=57
      #2  begin a_dir = 1'b1; b_dir = 1'b1; end           // t=59
      #3  check("nom_lshift_62", int'(ld_l_shift), 1);    // t=62
          check("nom_lcount_62", int'(l_count_enable), 1);
      #18 check("nom_lshift_80", int'(ld_l_shift), 1);    // t=80
      #9  begin a_dir = 1'b0; b_dir = 1'b0; end           // t=89
      #3  check("nom_lshift_off_92", int'(ld_l_shift), 0); // t=92
      #7  r_dir = 1'b1;                                   // t=99
      #3  check("nom_mult_no_rshift_102", int'(ld_r_shift), 0); // t=102
      #8  check("nom_rshift_110", int'(ld_r_shift), 1);   // t=110
          check("nom_rcount_110", int'(r_count_enable), 1);
      #20 check("nom_rshift_130", int'(ld_r_shift), 1);   // t=130
      #9  r_dir = 1'b0;                                   // t=139
      #3  check("nom_rshift_off_142", int'(ld_r_shift), 0); // t=142
      #8  check("nom_done_150", int'(done), 1);           // t=150
      #10 check("nom_done_160", int'(done), 0);           // t=160
      direct = 1'b0;

      run_op(0, 0, 0, 1);   // zero-shift operands
      run_op(3, 5, 2, 1);   // asymmetric normalisation
      run_op(1, 1, 1, 5);   // start held for five cycles

      // Reset held across edges with start high, then quiet idle after release.
      @(posedge clk); #1 begin initial_load_ps = 1'b0; start = 1'b1; end
      repeat (4) begin
         @(negedge clk);
         check("reset_outputs", int'(outs), 0);
      end
      #1 begin initial_load_ps = 1'b1; start = 1'b0; end
      repeat (4) begin
         @(negedge clk);
         check("idle_after_reset", int'(outs), 0);
      end

      // Abort during R_SHIFT: outputs must drop without waiting for an edge.
      a_cfg = 2; b_cfg = 1; r_cfg = 8;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen_r = 1'b0;
      for (int i = 0; i < 100 && !seen_r; i++) begin
         @(negedge clk);
         if (ld_r_shift) seen_r = 1'b1;
      end
      check("abort_reached_rshift", int'(seen_r), 1);
      #1 initial_load_ps = 1'b0;
      #1 check("abort_outputs_async", int'(outs), 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", int'(done), 0);
      end
      @(posedge clk); #1 initial_load_ps = 1'b1;

      run_op(2, 2, 2, 1);   // full run after abort
      run_op(4, 0, 3, 2);

      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
- Control FSM for the sequential approximate multiplier datapath. After a start pulse it:
  - clears the datapath,
  - loads operands A and B,
  - left-normalises them while the datapath reports leading-zero shifting,
  - lets the product settle,
  - right-shifts the result back while the datapath reports result shifting,
  - pulses done.
- Sits between the top-level handshake (start/done) and the datapath's shift registers and shift counters.

Parameters:
- None. State encoding is internal, 3 bits, 8 states.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- initial_load_ps  input  1  asynchronous, active-low reset; while 0 the FSM is held in IDLE.
- start  input  1  start request, level sampled on clk.
- a_shifting  input  1  datapath: operand A still being left-normalised.
- b_shifting  input  1  datapath: operand B still being left-normalised.
- r_shifting  input  1  datapath: result still being right-shifted.
- rst  output  1  synchronous clear to datapath registers and counters.
- ld  output  1  load operands A and B into the shift registers.
- ld_l_shift  output  1  left-shift enable for the operand registers.
- ld_r_shift  output  1  right-shift enable for the result register.
- l_count_enable  output  1  increment the left-shift counter.
- r_count_enable  output  1  increment the right-shift counter.
- done  output  1  operation complete; one-cycle pulse.

Behaviour:
- Reset: initial_load_ps=0 asynchronously forces state IDLE. All outputs are 0 while in reset and in IDLE. Reset asserted in any state, mid-operation included, aborts to IDLE with no done pulse.
- States and transitions, evaluated at each rising clk edge:
  - IDLE: start=1 -> WAIT_REL; otherwise stay.
  - WAIT_REL: start=0 -> INIT; otherwise stay, so a held start launches exactly one operation.
  - INIT: rst=1 for one cycle -> LOAD.
  - LOAD: ld=1 for one cycle -> L_SHIFT.
  - L_SHIFT: stay while (a_shifting | b_shifting); exit to MULT when both are 0.
  - MULT: one cycle, no outputs asserted (product register captures) -> R_SHIFT.
  - R_SHIFT: stay while r_shifting=1; exit to DONE when r_shifting=0.
  - DONE: done=1 for one cycle -> IDLE unconditionally. start is ignored in DONE.
- Outputs:
  - rst, ld and done are Moore outputs, decoded from state only.
  - In L_SHIFT only: ld_l_shift = l_count_enable = a_shifting | b_shifting (Mealy, combinational).
  - In R_SHIFT only: ld_r_shift = r_count_enable = r_shifting (Mealy).
  - In every other state all shift and count enables are 0.
- Mutual exclusion: at most one of rst, ld, ld_l_shift, ld_r_shift, done is ever high in a cycle.
- Zero-shift case: a_shifting=b_shifting=0 on entry to L_SHIFT spends exactly one cycle there with no enables. Likewise for r_shifting=0 on entry to R_SHIFT.
- Latency from the start falling edge to done with no shifting: INIT, LOAD, L_SHIFT, MULT, R_SHIFT, DONE, i.e. done is high in the 6th clock after WAIT_REL exits.
- Unknown or unused state encodings recover to IDLE on the next edge.

Test Plan:
- Reset: hold initial_load_ps=0 across several edges with start=1 -> all outputs 0, state IDLE. Release reset; no activity until start is seen.
- Nominal run (10 ns clock, edges at 5, 15, ...): start=1 over 20–30 ns; a_shifting=b_shifting=1 over 60–90 ns; r_shifting=1 over 100–140 ns. Required:
  - rst high in edge window 35–45,
  - ld high in 45–55,
  - ld_l_shift and l_count_enable high exactly while the shifting inputs are 1,
  - ld_r_shift and r_count_enable high exactly while r_shifting=1,
  - done=1 at 150 ns and 0 at 160 ns.
- Held start: keep start=1 for 5 cycles -> stays in WAIT_REL, no rst/ld until start falls; exactly one done per request.
- Asymmetric shifting: a_shifting=1 for 3 cycles, b_shifting=1 for 5 -> ld_l_shift and l_count_enable high for 5 cycles.
- Zero-shift operands: all shifting inputs 0 -> done exactly 6 cycles after start falls; no shift or count enable ever asserted.
- Abort: pull initial_load_ps low during R_SHIFT -> all outputs drop to 0 immediately, without waiting for a clock edge. No done pulse. After release, a new start runs a full sequence.
